// File: rtl/dac_spi_tx.sv
// rtl/dac_spi_tx.sv - serial DAC transmitter framing DDS samples into 12-bit SPI words
//
// Purpose: accepts DATA_W-bit samples on din/din_valid, frames each as
// {din, 2'b00} (MSB first) and shifts it out on cs_n/sclk/sdo. Samples that
// arrive while a frame is in flight are dropped, never queued.
//
// Parameters:
//   CLK_DIV  clk cycles per sclk half-period (2..255)
//   DATA_W   sample width; frame width is DATA_W+2
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   din         sample from the DDS stage
//   din_valid   sample strobe
//   ready       high only while idle; din_valid && ready accepts a sample
//   busy        inverse of ready
//   frame_done  one-cycle pulse when cs_n returns high
//   cs_n        DAC chip select, active low
//   sclk        serial clock, idle low
//   sdo         serial data to DAC DIN
//   drop_cnt    (only with DAC_SPI_DROP_CNT_EN) saturating count of samples
//               strobed while busy
//
// Build option: define DAC_SPI_DROP_CNT_EN to add the drop_cnt port and counter.

module dac_spi_tx #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              ready,
  output logic              busy,
  output logic              frame_done,
  output logic              cs_n,
  output logic              sclk,
  output logic              sdo
`ifdef DAC_SPI_DROP_CNT_EN
  ,
  output logic [15:0]       drop_cnt
`endif
);

  localparam int         FW        = DATA_W + 2;
  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [3:0] BITS_LAST = 4'(FW);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t        state_q;
  logic [FW-1:0] shift_q;
  logic [7:0]    div_q;
  logic [3:0]    bit_cnt_q;
  logic          ready_q;
  logic          busy_q;
  logic          frame_done_q;
  logic          cs_n_q;
  logic          sclk_q;
  logic          sdo_q;
  logic          tick;

  assign tick = (div_q == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      div_q        <= '0;
      bit_cnt_q    <= '0;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      cs_n_q       <= 1'b1;
      sclk_q       <= 1'b0;
      sdo_q        <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (din_valid) begin
            shift_q   <= {din, 2'b00};
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
            div_q     <= '0;
            bit_cnt_q <= '0;
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          // First SETUP cycle only drops cs_n and presents the MSB; the
          // divider starts running on the next cycle so sdo has a full
          // CLK_DIV cycles of setup before the first rising sclk.
          if (cs_n_q) begin
            cs_n_q <= 1'b0;
            sdo_q  <= shift_q[FW-1];
          end else if (tick) begin
            div_q     <= '0;
            sclk_q    <= 1'b1;
            bit_cnt_q <= 4'd1;
            state_q   <= SHIFT;
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
        SHIFT: begin
          if (tick) begin
            div_q  <= '0;
            sclk_q <= ~sclk_q;
            if (!sclk_q) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (bit_cnt_q == BITS_LAST) begin
              // Falling edge after the last rising edge closes the frame.
              cs_n_q       <= 1'b1;
              sdo_q        <= 1'b0;
              frame_done_q <= 1'b1;
              state_q      <= HOLD;
            end else begin
              shift_q <= shift_q << 1;
              sdo_q   <= shift_q[FW-2];
            end
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
        HOLD: begin
          if (tick) begin
            div_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready      = ready_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign cs_n       = cs_n_q;
  assign sclk       = sclk_q;
  assign sdo        = sdo_q;

`ifdef DAC_SPI_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else if (din_valid && !ready_q && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: doc/dac_spi_tx.md
# dac_spi_tx

Serial DAC transmitter that sits directly downstream of the DDS core in the signal generator. It accepts 10-bit samples with a valid strobe, frames each as a 12-bit word (10 data bits, MSB first, plus 2 trailing zero bits, TLC5615 format) and shifts it out on a 3-wire SPI interface (cs_n, sclk, sdo). Samples that arrive while a frame is in flight are dropped, never queued.

## Interface
- CLK_DIV, 4: clk cycles per sclk half-period; legal range 2..255.
- DATA_W, 10: sample width; frame width is DATA_W+2.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous active-high reset.
- din  input  DATA_W  sample from the DDS stage.
- din_valid  input  1  sample strobe; sampled every clk edge.
- ready  output  1  high only in IDLE; a sample is accepted on an edge where din_valid && ready.
- busy  output  1  inverse of ready.
- frame_done  output  1  one-cycle pulse when cs_n returns high.
- cs_n  output  1  DAC chip select, active low.
- sclk  output  1  serial clock, idle low.
- sdo  output  1  serial data to DAC DIN.

## Operation
- All outputs registered. Reset values: ready=1, busy=0, frame_done=0, cs_n=1, sclk=0, sdo=0; state IDLE; shift register, divider and bit counter cleared.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> IDLE.
- IDLE: on din_valid, load shift register with {din, 2'b00}, drive sdo = din[DATA_W-1], cs_n=0, ready=0, clear divider; go SETUP.
- SETUP: wait CLK_DIV cycles, then raise sclk; go SHIFT.
- SHIFT: every CLK_DIV cycles toggle sclk. On each falling sclk edge, shift left by one and present the next bit on sdo; sdo never changes on a rising edge. After the 12th rising edge, the next falling edge drives cs_n=1, sdo=0, pulses frame_done; go HOLD.
- HOLD: cs_n high for CLK_DIV cycles (DAC conversion/min-deselect time), then ready=1; go IDLE.
- Divider: counts 0..CLK_DIV-1; the tick occurs at CLK_DIV-1 and wraps to 0. Bit counter counts rising edges 0..12.
- din_valid while not ready: sample ignored; frame in flight unaffected.
- din is captured only at acceptance; later changes of din do not alter the frame.
- rst mid-frame: cs_n goes high and sclk low immediately (asynchronously); no partial frame resumes after reset release.

## Timing
- Acceptance at edge 0. cs_n falls and the first bit (MSB) appears on sdo after edge 1.
- Rising sclk edges after edges 1+CLK_DIV*(2k+1), k=0..11; falling sclk edges after edges 1+CLK_DIV*(2k+2).
- cs_n rises and frame_done pulses after edge 1+24*CLK_DIV; ready rises after edge 1+25*CLK_DIV.
- Next sample accepted no earlier than edge 2+25*CLK_DIV. Maximum sample rate is one per 25*CLK_DIV+2 clk cycles (102 at the default CLK_DIV=4).
- sclk high and low times are exactly CLK_DIV clk cycles each. sdo setup to a rising sclk edge is CLK_DIV cycles.

## Configuration
- DAC_SPI_DROP_CNT_EN defined: adds output drop_cnt [15:0], reset 0. It increments by one on every edge where din_valid && !ready, saturates at 16'hFFFF, and is cleared only by rst.
- Not defined: no drop_cnt port and no counter logic. All other behaviour is identical.

## Test plan
- Reset: assert rst mid-SHIFT -> cs_n=1, sclk=0, sdo=0, ready=1 within the same cycle; after release, no sclk activity until a new din_valid.
- Single frame, CLK_DIV=4, din=10'h2A5 -> monitor captures 12 bits on rising sclk = 1010100101_00; exactly 12 rising edges while cs_n low; frame_done pulses once, after edge 97.
- Back-to-back: din_valid held high with din=10'h3FF then 10'h001 -> frames transmitted with cs_n high for at least 4 cycles between them; acceptance edges 102 cycles apart.
- Busy drop: send din=10'h155 at edge 0 and din=10'h0AA at edge 10 -> only 10'h155 is transmitted; with DAC_SPI_DROP_CNT_EN, drop_cnt=1.
- Saturation (DAC_SPI_DROP_CNT_EN): force 70000 busy-cycle strobes -> drop_cnt holds at 16'hFFFF.
- CLK_DIV=2, din=10'h000 then 10'h3FF -> sclk period 4 cycles; data correct; ready rises after edge 51.
